// File: rtl/game_state_fsm_if.sv
// rtl/game_state_fsm_if.sv - game sequencer link to char ctrl, collision detector and HUD
interface game_state_fsm_if;
  logic       i_Start;
  logic       i_Has_Collided;
  logic       i_Level_Up;
  logic [3:0] i_Score;
  logic       o_Game_Active;
  logic       o_End_Game;
  logic [2:0] o_Lives;
  logic [2:0] o_State;
  logic       o_Hit_Flash;
  logic       o_Game_Over;
  logic       o_Win;

  modport master (
    input  i_Start, i_Has_Collided, i_Level_Up, i_Score,
    output o_Game_Active, o_End_Game, o_Lives, o_State,
    output o_Hit_Flash, o_Game_Over, o_Win
  );

  modport slave (
    output i_Start, i_Has_Collided, i_Level_Up, i_Score,
    input  o_Game_Active, o_End_Game, o_Lives, o_State,
    input  o_Hit_Flash, o_Game_Over, o_Win
  );
endinterface

// File: rtl/game_state_fsm.sv
// rtl/game_state_fsm.sv - frog game sequencer: lives and IDLE/PLAY/HIT/OVER/WIN flow
module game_state_fsm #(
  parameter int C_LIVES_INI      = 3,
  parameter int C_WIN_SCORE      = 9,
  parameter int C_RESPAWN_CYCLES = 12500000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_N,
  game_state_fsm_if.master      game_bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_OVER = 3'd3,
    ST_WIN  = 3'd4
  } state_t;

  localparam logic [2:0]  LP_LIVES_INI = 3'(C_LIVES_INI);
  localparam logic [3:0]  LP_WIN_SCORE = 4'(C_WIN_SCORE);
  localparam logic [31:0] LP_HIT_LAST  = 32'(C_RESPAWN_CYCLES - 1);

  state_t      r_State;
  logic [31:0] r_Count;
  logic        r_Start_Sync1;
  logic        r_Start_Sync2;
  logic        r_Start_Prev;
  logic        r_Coll_Prev;
  logic        w_Start_Rise;
  logic        w_Hit_Event;

  // Sync/edge regs reset high so a start held through reset release is not a start
  assign w_Start_Rise = r_Start_Sync2 & ~r_Start_Prev;
  assign w_Hit_Event  = game_bus.i_Has_Collided & ~r_Coll_Prev;
  assign game_bus.o_State = r_State;

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_State                <= ST_IDLE;
      r_Count                <= '0;
      r_Start_Sync1          <= 1'b1;
      r_Start_Sync2          <= 1'b1;
      r_Start_Prev           <= 1'b1;
      r_Coll_Prev            <= 1'b0;
      game_bus.o_Game_Active <= 1'b0;
      game_bus.o_End_Game    <= 1'b0;
      game_bus.o_Lives       <= LP_LIVES_INI;
      game_bus.o_Hit_Flash   <= 1'b0;
      game_bus.o_Game_Over   <= 1'b0;
      game_bus.o_Win         <= 1'b0;
    end else begin
      r_Start_Sync1       <= game_bus.i_Start;
      r_Start_Sync2       <= r_Start_Sync1;
      r_Start_Prev        <= r_Start_Sync2;
      r_Coll_Prev         <= game_bus.i_Has_Collided;
      game_bus.o_End_Game <= 1'b0;

      case (r_State)
        ST_IDLE, ST_OVER, ST_WIN: begin
          if (w_Start_Rise) begin
            r_State                <= ST_PLAY;
            game_bus.o_Lives       <= LP_LIVES_INI;
            game_bus.o_End_Game    <= 1'b1;
            game_bus.o_Game_Active <= 1'b1;
            game_bus.o_Game_Over   <= 1'b0;
            game_bus.o_Win         <= 1'b0;
          end
        end

        // A hit takes priority over a winning level-up in the same cycle
        ST_PLAY: begin
          if (w_Hit_Event) begin
            game_bus.o_Game_Active <= 1'b0;
            if (game_bus.o_Lives > 3'd1) begin
              r_State              <= ST_HIT;
              r_Count              <= '0;
              game_bus.o_Lives     <= game_bus.o_Lives - 3'd1;
              game_bus.o_Hit_Flash <= 1'b1;
            end else begin
              r_State              <= ST_OVER;
              game_bus.o_Lives     <= 3'd0;
              game_bus.o_Game_Over <= 1'b1;
            end
          end else if (game_bus.i_Level_Up && (game_bus.i_Score >= LP_WIN_SCORE)) begin
            r_State                <= ST_WIN;
            game_bus.o_Game_Active <= 1'b0;
            game_bus.o_Win         <= 1'b1;
          end
        end

        ST_HIT: begin
          if (r_Count == LP_HIT_LAST) begin
            r_State                <= ST_PLAY;
            game_bus.o_Game_Active <= 1'b1;
            game_bus.o_Hit_Flash   <= 1'b0;
          end else begin
            r_Count <= r_Count + 32'd1;
          end
        end

        default: begin
          r_State                <= ST_IDLE;
          game_bus.o_Game_Active <= 1'b0;
          game_bus.o_Hit_Flash   <= 1'b0;
          game_bus.o_Game_Over   <= 1'b0;
          game_bus.o_Win         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_fsm.sv
// tb/tb_game_state_fsm.sv - directed table-driven bench for game_state_fsm
module tb_game_state_fsm;

  typedef struct {
    logic       start;
    logic       coll;
    logic       lvl;
    logic [3:0] score;
    int         st;
    int         act;
    int         endg;
    int         lives;
    int         flash;
    int         over;
    int         win;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   hit_cycles;
  int   waited;
  vec_t vecs[16];

  game_state_fsm_if bus ();

  game_state_fsm #(
    .C_LIVES_INI      (3),
    .C_WIN_SCORE      (9),
    .C_RESPAWN_CYCLES (16)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_N  (rst_n),
    .game_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic c, logic l, logic [3:0] sc,
                              int st, int act, int endg, int lives,
                              int flash, int over, int win);
    vec_t v;
    v.start = s;  v.coll = c;   v.lvl = l;     v.score = sc;
    v.st = st;    v.act = act;  v.endg = endg; v.lives = lives;
    v.flash = flash; v.over = over; v.win = win;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".state"}, int'(bus.o_State), v.st);
    chk({tag, ".active"}, int'(bus.o_Game_Active), v.act);
    chk({tag, ".end_game"}, int'(bus.o_End_Game), v.endg);
    chk({tag, ".lives"}, int'(bus.o_Lives), v.lives);
    chk({tag, ".hit_flash"}, int'(bus.o_Hit_Flash), v.flash);
    chk({tag, ".game_over"}, int'(bus.o_Game_Over), v.over);
    chk({tag, ".win"}, int'(bus.o_Win), v.win);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // inputs: start coll lvl score | expected: state act end lives flash over win
    vecs[0]  = mk(0, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 4'd0, 1, 1, 1, 3, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 4'd0, 1, 1, 0, 3, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1, 4'd5, 1, 1, 0, 3, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, 4'd9, 4, 0, 0, 3, 0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 4'd9, 4, 0, 0, 3, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 4'd9, 4, 0, 0, 3, 0, 0, 1);
    vecs[11] = mk(0, 0, 0, 4'd9, 4, 0, 0, 3, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, 4'd9, 4, 0, 0, 3, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 4'd9, 4, 0, 0, 3, 0, 0, 1);
    vecs[14] = mk(1, 0, 0, 4'd9, 1, 1, 1, 3, 0, 0, 0);
    vecs[15] = mk(0, 1, 1, 4'd9, 2, 0, 0, 2, 1, 0, 0);

    rst_n              = 1'b0;
    bus.i_Start        = 1'b0;
    bus.i_Has_Collided = 1'b0;
    bus.i_Level_Up     = 1'b0;
    bus.i_Score        = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", mk(0, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.i_Start        = vecs[i].start;
      bus.i_Has_Collided = vecs[i].coll;
      bus.i_Level_Up     = vecs[i].lvl;
      bus.i_Score        = vecs[i].score;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end
    bus.i_Level_Up = 1'b0;

    // Respawn length with collision held, then a fresh pulse mid-HIT
    hit_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      bus.i_Has_Collided = (i < 4) || (i == 7);
      step();
      if (bus.o_State == 3'd1) break;
      hit_cycles++;
    end
    bus.i_Has_Collided = 1'b0;
    chk("hit_len", hit_cycles, 16);
    chk("respawn.lives", int'(bus.o_Lives), 2);
    chk("respawn.end_game", int'(bus.o_End_Game), 0);
    chk("respawn.active", int'(bus.o_Game_Active), 1);

    // Second and third hits: down to OVER, then a restart
    bus.i_Has_Collided = 1'b1;
    step();
    bus.i_Has_Collided = 1'b0;
    chk("hit2.state", int'(bus.o_State), 2);
    chk("hit2.lives", int'(bus.o_Lives), 1);
    waited = 0;
    while (bus.o_State != 3'd1 && waited < 40) begin
      step();
      waited++;
    end
    chk("hit2.back_to_play", int'(bus.o_State), 1);
    bus.i_Has_Collided = 1'b1;
    step();
    bus.i_Has_Collided = 1'b0;
    chk_all("over", mk(0, 0, 0, 4'd0, 3, 0, 0, 0, 0, 1, 0));
    bus.i_Start = 1'b1;
    step();
    step();
    chk("restart.wait", int'(bus.o_State), 3);
    step();
    chk_all("restart", mk(0, 0, 0, 4'd0, 1, 1, 1, 3, 0, 0, 0));
    step();
    chk("restart.end_once", int'(bus.o_End_Game), 0);
    bus.i_Start = 1'b0;
    repeat (4) step();

    // Async reset mid-HIT, released with start held high
    bus.i_Has_Collided = 1'b1;
    step();
    bus.i_Has_Collided = 1'b0;
    chk("hit3.state", int'(bus.o_State), 2);
    chk("hit3.lives", int'(bus.o_Lives), 2);
    repeat (7) step();
    chk("hit3.still_hit", int'(bus.o_State), 2);
    bus.i_Start = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", mk(0, 0, 0, 4'd0, 0, 0, 0, 3, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("held_start%0d", i), int'(bus.o_State), 0);
    end
    bus.i_Start = 1'b0;
    repeat (3) step();
    bus.i_Start = 1'b1;
    step();
    step();
    chk("post_rst.wait", int'(bus.o_State), 0);
    step();
    chk_all("post_rst.start", mk(0, 0, 0, 4'd0, 1, 1, 1, 3, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
